// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of {PC, Inst} packets between IF and ID.
// Flush (branch redirect) empties the queue in one cycle; reset dominates flush.
// Optional macro FETCH_QUEUE_BYPASS_EN adds a same-cycle in->out path when empty.
module fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             bypass_take;

  // Status decode, handshakes and head selection.
  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    in_ready = !full && !flush;
`ifdef FETCH_QUEUE_BYPASS_EN
    // An empty queue forwards the incoming packet; it is stored only if ID stalls.
    bypass_take = empty && in_valid && !flush && out_ready;
    out_valid   = (!empty || in_valid) && !flush;
    out_data    = empty ? in_data : mem[rd_ptr];
`else
    bypass_take = 1'b0;
    out_valid   = !empty && !flush;
    out_data    = mem[rd_ptr];
`endif
    push = in_valid && in_ready && !bypass_take;
    pop  = out_valid && out_ready && !empty;
  end

  // Pointer and occupancy update; reset and flush both clear the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Packet storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: table-driven vectors plus streaming and bypass sequences.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, full, empty;
  logic [63:0] in_data, out_data;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.WIDTH(64), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, fl, iv;
    logic [63:0] id;
    logic        ordy;
    logic        byp;     // row sees an empty queue with in_valid: bypass changes out_valid/out_data
    logic        e_ov, e_ir;
    int          e_cnt;
    logic        e_full, e_empty;
    logic [63:0] e_od;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic [63:0] id, logic ordy,
                              logic byp, logic e_ov, logic e_ir, int e_cnt,
                              logic e_full, logic e_empty, logic [63:0] e_od);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy; v.byp = byp;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_cnt = e_cnt; v.e_full = e_full;
    v.e_empty = e_empty; v.e_od = e_od;
    return v;
  endfunction

  function automatic logic [63:0] d(int k);
    return 64'h1C000000_00000000 + 64'(k);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic rst, logic fl, logic iv, logic [63:0] id, logic ordy);
    reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
  endtask

  // Check outputs mid-cycle, then advance past the next rising edge.
  task automatic run_vec(vec_t v, int idx);
    logic        ov_e;
    logic [63:0] od_e;
    drive(v.rst, v.fl, v.iv, v.id, v.ordy);
    ov_e = (v.byp && BYP) ? 1'b1 : v.e_ov;
    od_e = (v.byp && BYP) ? v.id : v.e_od;
    @(negedge clk);
    check($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'(ov_e));
    check($sformatf("v%0d in_ready", idx), 64'(in_ready), 64'(v.e_ir));
    check($sformatf("v%0d count", idx), 64'(count), 64'(v.e_cnt));
    check($sformatf("v%0d full", idx), 64'(full), 64'(v.e_full));
    check($sformatf("v%0d empty", idx), 64'(empty), 64'(v.e_empty));
    if (ov_e) check($sformatf("v%0d out_data", idx), out_data, od_e);
    @(posedge clk); #1;
  endtask

  initial begin
    // rst fl iv id ordy | byp ov ir cnt full empty od
    tbl.push_back(mk(0,0,0,64'h0,0, 0,0,1,0,0,1,64'h0));   // reset state
    // fill to 4, then drain in order
    tbl.push_back(mk(0,0,1,d(1),0, 1,0,1,0,0,1,64'h0));
    tbl.push_back(mk(0,0,1,d(2),0, 0,1,1,1,0,0,d(1)));
    tbl.push_back(mk(0,0,1,d(3),0, 0,1,1,2,0,0,d(1)));
    tbl.push_back(mk(0,0,1,d(4),0, 0,1,1,3,0,0,d(1)));
    tbl.push_back(mk(0,0,1,d(5),0, 0,1,0,4,1,0,d(1)));     // full: push refused
    tbl.push_back(mk(0,0,0,64'h0,1, 0,1,0,4,1,0,d(1)));
    tbl.push_back(mk(0,0,0,64'h0,1, 0,1,1,3,0,0,d(2)));
    tbl.push_back(mk(0,0,0,64'h0,1, 0,1,1,2,0,0,d(3)));
    tbl.push_back(mk(0,0,0,64'h0,1, 0,1,1,1,0,0,d(4)));
    tbl.push_back(mk(0,0,0,64'h0,0, 0,0,1,0,0,1,64'h0));
    // full boundary
    tbl.push_back(mk(0,0,1,d(1),0, 1,0,1,0,0,1,64'h0));
    tbl.push_back(mk(0,0,1,d(2),0, 0,1,1,1,0,0,d(1)));
    tbl.push_back(mk(0,0,1,d(3),0, 0,1,1,2,0,0,d(1)));
    tbl.push_back(mk(0,0,1,d(4),0, 0,1,1,3,0,0,d(1)));
    tbl.push_back(mk(0,0,1,d(5),1, 0,1,0,4,1,0,d(1)));     // pop only, 4->3
    tbl.push_back(mk(0,0,1,d(5),0, 0,1,1,3,0,0,d(2)));     // push accepted, 3->4
    tbl.push_back(mk(0,0,0,64'h0,0, 0,1,0,4,1,0,d(2)));
    tbl.push_back(mk(0,0,0,64'h0,1, 0,1,0,4,1,0,d(2)));    // pop to 3
    // flush mid-stream with push and pop requested
    tbl.push_back(mk(0,1,1,d(6),1, 0,0,0,3,0,0,64'h0));
    tbl.push_back(mk(0,0,0,64'h0,1, 0,0,1,0,0,1,64'h0));
    tbl.push_back(mk(0,0,1,d(7),0, 1,0,1,0,0,1,64'h0));
    tbl.push_back(mk(0,0,0,64'h0,1, 0,1,1,1,0,0,d(7)));    // flushed d6 never seen
    tbl.push_back(mk(0,0,0,64'h0,0, 0,0,1,0,0,1,64'h0));
    // reset mid-operation dominates flush
    tbl.push_back(mk(0,0,1,d(8),0, 1,0,1,0,0,1,64'h0));
    tbl.push_back(mk(0,0,1,d(9),0, 0,1,1,1,0,0,d(8)));
    tbl.push_back(mk(0,0,1,d(10),0, 0,1,1,2,0,0,d(8)));
    tbl.push_back(mk(1,1,0,64'h0,0, 0,0,0,3,0,0,64'h0));
    tbl.push_back(mk(0,0,0,64'h0,0, 0,0,1,0,0,1,64'h0));

    drive(1, 0, 0, 64'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Streaming: preload 2, then 20 cycles of push+pop with wrap-around.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 64'h1C000000_00000100 + 64'(i), 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 64'h1C000000_00000100 + 64'(i + 2), 1);
      @(negedge clk);
      check($sformatf("stream%0d count", i), 64'(count), 64'd2);
      check($sformatf("stream%0d out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("stream%0d in_ready", i), 64'(in_ready), 64'd1);
      check($sformatf("stream%0d out_data", i), out_data, 64'h1C000000_00000100 + 64'(i));
      @(posedge clk); #1;
    end
    for (int i = 20; i < 22; i++) begin
      drive(0, 0, 0, 64'h0, 1);
      @(negedge clk);
      check($sformatf("drain%0d out_data", i), out_data, 64'h1C000000_00000100 + 64'(i));
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 64'h0, 0);
    @(negedge clk);
    check("drain empty", 64'(empty), 64'd1);
    @(posedge clk); #1;

    // Bypass / minimum-latency sequence on an empty queue.
    drive(0, 0, 1, 64'h1C000010_02800421, 1);
    @(negedge clk);
    check("byp out_valid", 64'(out_valid), 64'(BYP));
    if (BYP) check("byp out_data", out_data, 64'h1C000010_02800421);
    @(posedge clk); #1;
    drive(0, 0, 0, 64'h0, 1);
    @(negedge clk);
    if (BYP) begin
      check("byp next count", 64'(count), 64'd0);
      check("byp next out_valid", 64'(out_valid), 64'd0);
    end else begin
      check("lat1 count", 64'(count), 64'd1);
      check("lat1 out_valid", 64'(out_valid), 64'd1);
      check("lat1 out_data", out_data, 64'h1C000010_02800421);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 64'h0, 0);
    @(negedge clk);
    check("final empty", 64'(empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised, flushable instruction fetch queue placed between the IF and ID stages. It generalises the single-entry IF/ID valid/ready handoff into a DEPTH-entry FIFO of WIDTH-bit {PC, Inst} packets. IF can keep fetching while ID stalls. A branch redirect from EXE empties the queue in one cycle. An optional same-cycle bypass path is available when the queue is empty.

## Interface
Parameters:
- WIDTH, 64, packet width; packet is {PC[63:32], Inst[31:0]} at the default.
- DEPTH, 4, number of entries; must be a power of two and ≥ 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- flush  input  1  redirect from EXE; discards all entries.
- in_valid  input  1  IF has a packet.
- in_ready  output  1  queue accepts a packet this cycle.
- in_data  input  WIDTH  packet from IF.
- out_valid  output  1  head packet available to ID.
- out_ready  input  1  ID consumes the head this cycle.
- out_data  output  WIDTH  head packet.
- count  output  $clog2(DEPTH)+1  number of stored entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

## Operation
- Storage is a DEPTH x WIDTH register array, with a write pointer and a read pointer, each $clog2(DEPTH) bits.
- Pointers wrap modulo DEPTH by natural overflow.
- count is held as a register and is not derived from the pointers.
- push = in_valid & in_ready.
- pop = out_valid & out_ready & !empty. A pop is taken from storage, not from the bypass path.
- in_ready = !full & !flush. There is no pop-while-full acceptance, so in_ready has no combinational path from out_ready.
- out_valid = !empty & !flush when bypass is not compiled in.
- out_data = mem[rd_ptr] when not empty.
- Push only: write in_data at wr_ptr, then wr_ptr+1 and count+1.
- Pop only: rd_ptr+1 and count-1.
- Push and pop in the same cycle, queue neither empty nor full: both pointers advance and count is unchanged.
- Flush has priority over push and pop in the same cycle. At the next edge, rd_ptr = wr_ptr = 0 and count = 0. The incoming packet is discarded.
- Storage array contents are not reset and are don't-care while empty.
- full and empty are decoded combinationally from count.

## Timing
- Reset: count=0 and both pointers 0. This gives empty=1, full=0, out_valid=0, in_ready=1 (with flush=0). out_data is don't-care.
- Reset asserted mid-operation drops all entries at the next edge. Reset dominates flush.
- Latency without bypass: a packet pushed at edge N is visible on out_valid/out_data in the cycle after edge N, i.e. 1 cycle.
- Throughput: 1 packet/cycle sustained when 0 < count < DEPTH.
- When full, one bubble cycle on in_ready follows each pop.
- In the cycle flush is asserted, out_valid=0 and in_ready=0. ID must not see a stale head during a redirect.
- A push presented while full is not taken. in_valid/in_data must be held by IF until in_ready.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When empty & in_valid & !flush, out_valid=1 and out_data=in_data combinationally.
  - If out_ready=1 in that cycle, the packet passes straight through. It is not stored, and count stays 0.
  - If out_ready=0, the packet is pushed normally.
  - Zero-cycle latency on the empty queue.
- FETCH_QUEUE_BYPASS_EN not defined: no in→out combinational path, and minimum latency is 1 cycle as above.

## Test plan
- Reset then fill: hold out_ready=0 and push 0x1C000000_00000001..4. Required: count reaches 4, full=1, in_ready=0. Then pop 4 times: out_data in the same order, empty=1.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with count=2 preloaded. Required: count stays 2, one pop per cycle, in-order data, pointers wrap past DEPTH-1 without loss.
- Flush mid-stream: count=3, assert flush together with in_valid=1 and out_ready=1. Required: out_valid=0 and in_ready=0 that cycle; count=0 next cycle; the flushed-cycle packet is never output.
- Full boundary: full queue with in_valid=1 and out_ready=1. Required: pop taken, no push that cycle (count 4→3); push accepted the next cycle (count 3→4).
- Bypass (with FETCH_QUEUE_BYPASS_EN): empty queue, in_data=0x1C000010_02800421, in_valid=1, out_ready=1. Required: out_valid=1 and out_data equal to in_data in the same cycle; count stays 0. Without the macro: out_valid=0 that cycle, data appears the next cycle with count=1.
- Reset mid-operation: count=3 with reset and flush both high. Required: next cycle count=0, empty=1, in_ready=1.
